page_stream_in_q: RTL and testbench

//  Receive-side stream queue for one TDF page input. Accepts {data,eos} tokens

---
 rtl/page_stream_in_q_if.sv | 27 ++
 rtl/page_stream_in_q.sv | 75 +++++++
 tb/tb_page_stream_in_q.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/page_stream_in_q_if.sv
// Link bundle between an upstream page output queue and the receive-side stream queue.
// The queue side uses the slave modport; the side that drives tokens and consumes the head uses master.
interface page_stream_in_q_if #(
   parameter int DW = 9,
   parameter int AW = 4
);
   logic [DW-1:0] qin_d;
   logic          qin_e;
   logic          qin_v;
   logic          qin_b;
   logic [DW-1:0] qout_d;
   logic          qout_e;
   logic          qout_v;
   logic          qout_b;
   logic [AW:0]   count;
   logic          ovf_err;

   modport slave (
      input  qin_d, qin_e, qin_v, qout_b,
      output qin_b, qout_d, qout_e, qout_v, count, ovf_err
   );

   modport master (
      output qin_d, qin_e, qin_v, qout_b,
      input  qin_b, qout_d, qout_e, qout_v, count, ovf_err
   );
endinterface

// File: rtl/page_stream_in_q.sv
// Receive-side FWFT token queue for one page input. It raises qin_b early so that
// SLACK tokens already in flight on the link still find free storage.
module page_stream_in_q #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DW    = 9,
   parameter int SLACK = 2
) (
   input  logic              clock,
   input  logic              reset,
   page_stream_in_q_if.slave q
);

   localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
   localparam logic [AW:0] THRESH = (AW+1)'(DEPTH - SLACK);

   logic [DW:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   logic          qin_b;
   logic          ovf_err;
   logic          full;
   logic          nonempty;
   logic          push;
   logic          pop;

   assign full     = (count == FULL);
   assign nonempty = (count != '0);
   assign pop      = nonempty & ~q.qout_b;
   // A pop on the same edge frees the slot, so a full queue can still accept.
   assign push     = q.qin_v & (~full | pop);

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + (AW+1)'(1);
      else if (pop && !push)
         count_next = count - (AW+1)'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         qin_b   <= 1'b0;
         ovf_err <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         qin_b <= (count_next >= THRESH);
         if (q.qin_v && !push)
            ovf_err <= 1'b1;
      end
   end

   // Storage is deliberately not cleared by reset; qout_v masks stale entries.
   always_ff @(posedge clock) begin
      if (push && !reset)
         mem[wr_ptr] <= {q.qin_d, q.qin_e};
   end

   assign q.qin_b   = qin_b;
   assign q.qout_v  = nonempty;
   assign q.qout_d  = mem[rd_ptr][DW:1];
   assign q.qout_e  = mem[rd_ptr][0];
   assign q.count   = count;
   assign q.ovf_err = ovf_err;

endmodule

// File: tb/tb_page_stream_in_q.sv
// Bench for page_stream_in_q: directed scenarios plus random traffic against a queue-based model.
module tb_page_stream_in_q;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int DW    = 9;
   localparam int SLACK = 2;

   logic clock;
   logic reset;
   int   n_cmp;
   int   n_bad;

   logic [DW:0] mq[$];
   logic        m_ovf;
   logic        m_qinb;
   logic [DW-1:0] popped[$];

   page_stream_in_q_if #(.DW(DW), .AW(AW)) bus ();

   page_stream_in_q #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .SLACK(SLACK)) dut (
      .clock (clock),
      .reset (reset),
      .q     (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("qout_v", 32'(bus.qout_v), 32'(mq.size() != 0));
      chk("qin_b", 32'(bus.qin_b), 32'(m_qinb));
      chk("ovf_err", 32'(bus.ovf_err), 32'(m_ovf));
      if (mq.size() != 0) begin
         chk("qout_d", 32'(bus.qout_d), 32'(mq[0][DW:1]));
         chk("qout_e", 32'(bus.qout_e), 32'(mq[0][0]));
      end
   endtask

   // One clock: apply inputs, advance the model by the queue rules, check after the edge.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic e,
                       input logic b, input logic rst);
      logic do_pop;
      logic do_push;
      logic [DW:0] tmp;
      bus.qin_v  = v;
      bus.qin_d  = d;
      bus.qin_e  = e;
      bus.qout_b = b;
      reset      = rst;
      if (rst) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_qinb = 1'b0;
      end else begin
         do_pop  = (mq.size() != 0) && !b;
         do_push = v && ((mq.size() < DEPTH) || do_pop);
         if (do_pop) begin
            popped.push_back(bus.qout_d);
            tmp = mq.pop_front();
         end
         if (do_push)
            mq.push_back({d, e});
         else if (v)
            m_ovf = 1'b1;
         m_qinb = (mq.size() >= DEPTH - SLACK);
      end
      @(posedge clock);
      #1;
      check_all();
   endtask

   initial begin
      int sent;
      int cyc;
      n_cmp = 0;
      n_bad = 0;
      bus.qin_v = 0; bus.qin_d = '0; bus.qin_e = 0; bus.qout_b = 1;
      reset = 1;
      mq.delete();
      m_ovf = 0;
      m_qinb = 0;

      // Reset state
      step(0, '0, 0, 1, 1);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_qout_v", 32'(bus.qout_v), 0);

      // T1 fill with consumer stalled
      for (int i = 0; i < DEPTH; i++) begin
         step(1, 9'($urandom), 1'($urandom), 1, 0);
         if (i == 12) chk("t1_qinb_13", 32'(bus.qin_b), 0);
         if (i == 13) chk("t1_qinb_14", 32'(bus.qin_b), 1);
      end
      chk("t1_count", 32'(bus.count), DEPTH);
      chk("t1_ovf", 32'(bus.ovf_err), 0);

      // T2 overflow then drain: flag is sticky
      step(1, 9'h0AA, 0, 1, 0);
      chk("t2_ovf", 32'(bus.ovf_err), 1);
      chk("t2_count", 32'(bus.count), DEPTH);
      for (int i = 0; i < DEPTH; i++) step(0, '0, 0, 0, 0);
      chk("t2_drained", 32'(bus.count), 0);
      chk("t2_ovf_hold", 32'(bus.ovf_err), 1);

      // T4 full with simultaneous pop
      step(0, '0, 0, 1, 1);
      for (int i = 0; i < DEPTH; i++) step(1, 9'(i + 9'h40), 0, 1, 0);
      step(1, 9'h155, 1, 0, 0);
      chk("t4_count", 32'(bus.count), DEPTH);
      chk("t4_ovf", 32'(bus.ovf_err), 0);
      chk("t4_head", 32'(bus.qout_d), 32'h41);

      // T5 eos token into empty queue, one-cycle latency
      step(0, '0, 0, 1, 1);
      step(1, 9'h1FF, 1, 1, 0);
      chk("t5_v", 32'(bus.qout_v), 1);
      chk("t5_d", 32'(bus.qout_d), 32'h1FF);
      chk("t5_e", 32'(bus.qout_e), 1);

      // T3 ordered 40 tokens with random consumer stalls, upstream obeys qin_b
      step(0, '0, 0, 1, 1);
      popped.delete();
      sent = 0;
      cyc = 0;
      while ((sent < 40 || mq.size() != 0) && cyc < 2000) begin
         logic v;
         v = (sent < 40) && !bus.qin_b && ($urandom_range(0, 3) != 0);
         step(v, 9'(sent), 1'(sent), 1'($urandom_range(0, 1)), 0);
         if (v) sent++;
         cyc++;
      end
      chk("t3_sent", 32'(sent), 40);
      chk("t3_popped", 32'(popped.size()), 40);
      for (int i = 0; i < popped.size() && i < 40; i++)
         chk("t3_order", 32'(popped[i]), 32'(i));
      chk("t3_ovf", 32'(bus.ovf_err), 0);
      chk("t3_empty", 32'(bus.qout_v), 0);

      // T6 reset mid-operation: count 9 with ovf set
      for (int i = 0; i < DEPTH + 1; i++) step(1, 9'($urandom), 0, 1, 0);
      for (int i = 0; i < 7; i++) step(0, '0, 0, 0, 0);
      chk("t6_pre_count", 32'(bus.count), 9);
      chk("t6_pre_ovf", 32'(bus.ovf_err), 1);
      step(0, '0, 0, 1, 1);
      chk("t6_count", 32'(bus.count), 0);
      chk("t6_qout_v", 32'(bus.qout_v), 0);
      chk("t6_qin_b", 32'(bus.qin_b), 0);
      chk("t6_ovf", 32'(bus.ovf_err), 0);
      step(1, 9'h123, 1, 1, 0);
      step(1, 9'h0F0, 0, 1, 0);
      chk("t6_after_head", 32'(bus.qout_d), 32'h123);

      // Random traffic, including overflow bursts and occasional reset
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 2) != 0), 9'($urandom), 1'($urandom),
              1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 99) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
